sfifo_watermark: RTL and testbench
==================================

SFIFO_WATERMARK -- requirements
Module: sfifo_watermark

Interface
REQ-001 SHALL have parameter BW, default 8, data width in bits.
REQ-002 SHALL have parameter LGFLEN, default 4, log2 of depth; FLEN = 2^LGFLEN entries.
REQ-003 SHALL have parameter OPT_ASYNC_READ, default 1, 1 = combinational head read, 0 = registered memory read.
REQ-004 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_wr  input  1  write request.
REQ-007 SHALL have port i_data  input  BW  write data.
REQ-008 SHALL have port o_full  output  1  fill == FLEN.
REQ-009 SHALL have port o_fill  output  LGFLEN+1  current occupancy.
REQ-010 SHALL have port i_rd  input  1  read request.
REQ-011 SHALL have port o_data  output  BW  head entry, valid while !o_empty.
REQ-012 SHALL have port o_empty  output  1  fill == 0.
REQ-013 SHALL have port i_hi_thresh  input  LGFLEN+1  upper watermark.
REQ-014 SHALL have port i_lo_thresh  input  LGFLEN+1  lower watermark.
REQ-015 SHALL have port i_int_en  input  3  interrupt enables {underflow, overflow, above}.
REQ-016 SHALL have port i_int_clr  input  1  clear all sticky flags.
REQ-017 SHALL have port o_above  output  1  hysteretic watermark state.
REQ-018 SHALL have port o_overflow  output  1  sticky: write attempted while full.
REQ-019 SHALL have port o_underflow  output  1  sticky: read attempted while empty.
REQ-020 SHALL have port o_int  output  1  sticky interrupt.

Function
REQ-021 SHALL accept a write (w_wr) iff i_wr && !o_full; a write while full is dropped, even if a read is accepted that cycle.
REQ-022 SHALL accept a read (w_rd) iff i_rd && !o_empty.
REQ-023 SHALL compute next_fill = o_fill + w_wr - w_rd and register it as o_fill; simultaneous accepted read and write leave o_fill unchanged.
REQ-024 SHALL use LGFLEN+1-bit read/write pointers wrapping modulo 2^(LGFLEN+1), memory indexed by the low LGFLEN bits.
REQ-025 SHALL register o_full and o_empty from next_fill; o_empty deasserts the cycle after the first accepted write, in both OPT_ASYNC_READ modes.
REQ-026 SHALL present entries on o_data in write order; with OPT_ASYNC_READ=0 o_data comes from a register, with write-to-output bypass when the FIFO is empty or holds one entry being read.
REQ-027 SHALL set o_above next cycle when next_fill >= i_hi_thresh, clear it when next_fill <= i_lo_thresh, otherwise hold it.
REQ-028 SHALL give set priority when both watermark conditions hold (i_lo_thresh >= i_hi_thresh).
REQ-029 SHALL never assert o_above from a threshold above FLEN; i_hi_thresh = 0 keeps o_above asserted.
REQ-030 SHALL set o_overflow on i_wr && o_full and o_underflow on i_rd && o_empty, holding each until i_int_clr.
REQ-031 SHALL set o_int the cycle after an enabled event: rising o_above (0 to 1), new overflow, or new underflow.
REQ-032 SHALL hold o_int until i_int_clr; i_int_clr clears o_int, o_overflow, o_underflow.
REQ-033 SHALL give a set event priority over i_int_clr in the same cycle.
REQ-034 SHALL NOT let i_int_clr affect o_above or FIFO contents.

Reset
REQ-035 SHALL, on i_reset_n low, immediately and regardless of clock force: pointers 0, o_fill 0, o_empty 1, o_full 0, o_above 0, o_overflow 0, o_underflow 0, o_int 0.
REQ-036 SHALL, with OPT_ASYNC_READ=0, also reset the o_data register to 0; memory contents are not reset.
REQ-037 SHALL discard in-flight requests when reset asserts mid-operation and accept requests from the first rising edge after i_reset_n deasserts.

Verification (BW=8, LGFLEN=4, both OPT_ASYNC_READ values)
REQ-038 SHALL cover: write 0x00..0x0F, then 16 reads -> o_full after 16th write, data 0x00..0x0F in order, o_empty after last read.
REQ-039 SHALL cover: hi=12, lo=4, i_int_en=3'b001, fill to 12 -> o_above and o_int rise together the cycle after the 12th write; drain to 5 -> o_above stays 1; at 4 -> o_above 0.
REQ-040 SHALL cover: full FIFO, i_wr=1 with i_rd=1 for 1 cycle -> o_fill 15, o_overflow 1, dropped data never appears on o_data.
REQ-041 SHALL cover: empty FIFO, i_rd=1 with i_int_en=3'b100 -> o_underflow 1 and o_int 1; i_int_clr pulse -> both 0; clr coincident with a new underflow -> both stay 1.
REQ-042 SHALL cover: fill=8 with o_int=1, i_reset_n low for half a cycle -> all outputs at reset values before next clock edge.
REQ-043 SHALL cover: 200 cycles of random i_wr/i_rd with reference model -> o_fill, o_full, o_empty, o_data match every cycle through pointer wrap.

Source files
------------

// File: rtl/sfifo_watermark_if.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_watermark_if
// Description : Write/read/status bundle for the synchronous watermark FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface sfifo_watermark_if #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
);
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              o_full;
  logic [LGFLEN:0]   o_fill;
  logic              i_rd;
  logic [BW-1:0]     o_data;
  logic              o_empty;

  modport master (
    output i_wr, i_data, i_rd,
    input  o_full, o_fill, o_data, o_empty
  );

  modport slave (
    input  i_wr, i_data, i_rd,
    output o_full, o_fill, o_data, o_empty
  );
endinterface
`default_nettype wire

// File: rtl/sfifo_watermark.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_watermark
// Description : Synchronous FIFO with hysteretic watermark, sticky
//               overflow/underflow flags and a maskable sticky interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module sfifo_watermark #(
  parameter int BW             = 8,
  parameter int LGFLEN         = 4,
  parameter int OPT_ASYNC_READ = 1
) (
  input  wire                i_clk,
  input  wire                i_reset_n,
  sfifo_watermark_if.slave   bus,
  input  wire [LGFLEN:0]     i_hi_thresh,
  input  wire [LGFLEN:0]     i_lo_thresh,
  input  wire [2:0]          i_int_en,
  input  wire                i_int_clr,
  output logic               o_above,
  output logic               o_overflow,
  output logic               o_underflow,
  output logic               o_int
);

  localparam int              c_FLEN = 1 << LGFLEN;
  localparam logic [LGFLEN:0] c_FULL = c_FLEN[LGFLEN:0];
  localparam logic [LGFLEN:0] c_ONE  = 1;

  logic [LGFLEN:0] r_wptr;
  logic [LGFLEN:0] r_rptr;
  logic [LGFLEN:0] r_fill;
  logic            r_full;
  logic            r_empty;
  logic            r_above;
  logic            r_overflow;
  logic            r_underflow;
  logic            r_int;
  logic [BW-1:0]   r_mem [c_FLEN];

  logic            w_wr;
  logic            w_rd;
  logic            w_ovf_ev;
  logic            w_unf_ev;
  logic [LGFLEN:0] w_next_fill;
  logic            w_above_next;
  logic            w_int_ev;

  always_comb begin
    w_wr     = bus.i_wr && !r_full;
    w_rd     = bus.i_rd && !r_empty;
    w_ovf_ev = bus.i_wr && r_full;
    w_unf_ev = bus.i_rd && r_empty;

    w_next_fill = r_fill;
    if (w_wr && !w_rd) begin
      w_next_fill = r_fill + c_ONE;
    end else if (!w_wr && w_rd) begin
      w_next_fill = r_fill - c_ONE;
    end

    // Set wins over clear so overlapping thresholds resolve to "above".
    w_above_next = r_above;
    if (w_next_fill >= i_hi_thresh) begin
      w_above_next = 1'b1;
    end else if (w_next_fill <= i_lo_thresh) begin
      w_above_next = 1'b0;
    end

    w_int_ev = (i_int_en[0] && w_above_next && !r_above)
            || (i_int_en[1] && w_ovf_ev)
            || (i_int_en[2] && w_unf_ev);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fill      <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_above     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + c_ONE;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + c_ONE;
      end
      r_fill  <= w_next_fill;
      r_full  <= (w_next_fill == c_FULL);
      r_empty <= (w_next_fill == '0);
      r_above <= w_above_next;

      if (w_ovf_ev) begin
        r_overflow <= 1'b1;
      end else if (i_int_clr) begin
        r_overflow <= 1'b0;
      end

      if (w_unf_ev) begin
        r_underflow <= 1'b1;
      end else if (i_int_clr) begin
        r_underflow <= 1'b0;
      end

      if (w_int_ev) begin
        r_int <= 1'b1;
      end else if (i_int_clr) begin
        r_int <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && i_reset_n) begin
      r_mem[r_wptr[LGFLEN-1:0]] <= bus.i_data;
    end
  end

  generate
    if (OPT_ASYNC_READ != 0) begin : g_async_read
      assign bus.o_data = r_mem[r_rptr[LGFLEN-1:0]];
    end else begin : g_sync_read
      logic [LGFLEN:0] w_rptr_next;
      logic [BW-1:0]   r_data;

      assign w_rptr_next = w_rd ? (r_rptr + c_ONE) : r_rptr;

      // When the next head is the slot being written this cycle, the memory
      // still holds stale data there, so forward the write data instead.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_data <= '0;
        end else if (w_wr && (w_rptr_next == r_wptr)) begin
          r_data <= bus.i_data;
        end else begin
          r_data <= r_mem[w_rptr_next[LGFLEN-1:0]];
        end
      end

      assign bus.o_data = r_data;
    end
  endgenerate

  assign bus.o_fill  = r_fill;
  assign bus.o_full  = r_full;
  assign bus.o_empty = r_empty;
  assign o_above     = r_above;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
  assign o_int       = r_int;

endmodule
`default_nettype wire

// File: tb/tb_sfifo_watermark.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfifo_watermark
// Description : Randomised and directed bench; both read modes run side by
//               side against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfifo_watermark;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, rd, clr;
  logic [7:0] data;
  logic [4:0] hi, lo;
  logic [2:0] en;

  logic above_a, ovf_a, unf_a, int_a;
  logic above_s, ovf_s, unf_s, int_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  bit m_above, m_ovf, m_unf, m_int;

  always #5 clk = ~clk;

  sfifo_watermark_if #(.BW(8), .LGFLEN(4)) ifa ();
  sfifo_watermark_if #(.BW(8), .LGFLEN(4)) ifs ();

  assign ifa.i_wr = wr;  assign ifa.i_rd = rd;  assign ifa.i_data = data;
  assign ifs.i_wr = wr;  assign ifs.i_rd = rd;  assign ifs.i_data = data;

  sfifo_watermark #(.BW(8), .LGFLEN(4), .OPT_ASYNC_READ(1)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .bus(ifa),
    .i_hi_thresh(hi), .i_lo_thresh(lo), .i_int_en(en), .i_int_clr(clr),
    .o_above(above_a), .o_overflow(ovf_a), .o_underflow(unf_a), .o_int(int_a)
  );

  sfifo_watermark #(.BW(8), .LGFLEN(4), .OPT_ASYNC_READ(0)) u_dut_s (
    .i_clk(clk), .i_reset_n(rst_n), .bus(ifs),
    .i_hi_thresh(hi), .i_lo_thresh(lo), .i_int_en(en), .i_int_clr(clr),
    .o_above(above_s), .o_overflow(ovf_s), .o_underflow(unf_s), .o_int(int_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_above = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_int   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] fill;
    logic [7:0] dout;
    logic       full, empty, ab, ov, un, it;
    string      pre;
    for (int d = 0; d < 2; d++) begin
      pre   = d ? "sync" : "async";
      fill  = d ? ifs.o_fill  : ifa.o_fill;
      dout  = d ? ifs.o_data  : ifa.o_data;
      full  = d ? ifs.o_full  : ifa.o_full;
      empty = d ? ifs.o_empty : ifa.o_empty;
      ab    = d ? above_s : above_a;
      ov    = d ? ovf_s   : ovf_a;
      un    = d ? unf_s   : unf_a;
      it    = d ? int_s   : int_a;
      chk($sformatf("%s.%s.fill", pre, tag), fill, q.size());
      chk($sformatf("%s.%s.full", pre, tag), full, q.size() == 16);
      chk($sformatf("%s.%s.empty", pre, tag), empty, q.size() == 0);
      chk($sformatf("%s.%s.above", pre, tag), ab, m_above);
      chk($sformatf("%s.%s.overflow", pre, tag), ov, m_ovf);
      chk($sformatf("%s.%s.underflow", pre, tag), un, m_unf);
      chk($sformatf("%s.%s.int", pre, tag), it, m_int);
      if (q.size() != 0) begin
        chk($sformatf("%s.%s.data", pre, tag), dout, q[0]);
      end
    end
  endtask

  // One clock: evaluate the model on the inputs present at the edge, then
  // compare every output shortly after the edge.
  task automatic cycle(input string tag);
    int         sz;
    int         nf;
    bit         aw, ar, oe, ue, nab, iev;
    logic [7:0] d_in;
    sz   = q.size();
    aw   = wr && (sz < 16);
    ar   = rd && (sz > 0);
    oe   = wr && (sz == 16);
    ue   = rd && (sz == 0);
    nf   = sz + int'(aw) - int'(ar);
    nab  = (nf >= int'(hi)) ? 1'b1 : ((nf <= int'(lo)) ? 1'b0 : m_above);
    iev  = (en[0] && nab && !m_above) || (en[1] && oe) || (en[2] && ue);
    d_in = data;
    @(posedge clk);
    #1;
    if (ar) void'(q.pop_front());
    if (aw) q.push_back(d_in);
    m_above = nab;
    m_ovf   = oe  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf   = ue  ? 1'b1 : (clr ? 1'b0 : m_unf);
    m_int   = iev ? 1'b1 : (clr ? 1'b0 : m_int);
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
    data = 8'h00; hi = 5'd17; lo = 5'd0; en = 3'b000;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // In-order fill/drain; a threshold above depth must never raise o_above.
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data = 8'(i); cycle("fill16");
    end
    wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1; cycle("drain16");
    end
    rd = 1'b0;

    hi = 5'd12; lo = 5'd4; en = 3'b001;
    for (int i = 0; i < 12; i++) begin
      wr = 1'b1; data = 8'(8'h20 + i); cycle("wm_fill");
    end
    wr = 1'b0;
    cycle("wm_hold");
    for (int i = 0; i < 12; i++) begin
      rd = 1'b1; cycle("wm_drain");
    end
    rd = 1'b0;
    clr = 1'b1; cycle("wm_clr"); clr = 1'b0;

    hi = 5'd17; lo = 5'd0; en = 3'b010;
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data = 8'(8'h40 + i); cycle("ovf_fill");
    end
    data = 8'hAA; rd = 1'b1; cycle("ovf_wr_rd");
    wr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle("ovf_drain");
    end
    rd = 1'b0;
    clr = 1'b1; cycle("ovf_clr"); clr = 1'b0;

    en = 3'b100;
    rd = 1'b1; cycle("unf_set");
    rd = 1'b0; cycle("unf_hold");
    clr = 1'b1; cycle("unf_clr");
    rd = 1'b1; cycle("unf_clr_set");
    rd = 1'b0; clr = 1'b0; cycle("unf_after");

    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; data = 8'(8'h60 + i); cycle("pre_rst");
    end
    data = 8'hEE;
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    #3 rst_n = 1'b1;
    wr = 1'b0;
    cycle("post_rst");
    wr = 1'b1; data = 8'h5A; cycle("first_wr");
    wr = 1'b0;

    hi = 5'd0; lo = 5'd0;
    cycle("hi0");
    rd = 1'b1; cycle("hi0_empty");
    rd = 1'b0;
    clr = 1'b1; cycle("hi0_clr"); clr = 1'b0;

    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) begin
        hi = 5'($urandom_range(0, 17));
        lo = 5'($urandom_range(0, 17));
        en = 3'($urandom_range(0, 7));
      end
      wr   = 1'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      clr  = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    wr = 1'b0; rd = 1'b0; clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
